// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse-wave voice.
// - duty_e          : duty-cycle selector carried with each note
// - DUTY_THRESHOLD  : per-duty compare value against the top 3 phase bits,
//                     i.e. the number of eighths of the period spent high
package pulse_pkg;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_e;

    localparam logic [2:0] DUTY_THRESHOLD [4] = '{3'd1, 3'd2, 3'd4, 3'd6};

    function automatic logic [2:0] duty_threshold(input duty_e duty);
        return DUTY_THRESHOLD[duty];
    endfunction

endpackage

// File: rtl/pulse_envelope.sv
// Volume envelope for one pulse voice.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - note trigger; loads level from volume and clears the wrap count
//   wrap      - one phase-accumulator wrap happened this cycle
//   period    - wraps per envelope step (0 holds the level constant)
//   volume    - level loaded on trigger and reloaded when looping
//   loop      - reload volume once the level has decayed to 0
//   level     - current envelope level
module pulse_envelope
    import pulse_pkg::*;
#(
    parameter int OUT_WIDTH   = 9,
    parameter int DECAY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   wrap,
    input  logic [DECAY_WIDTH-1:0] period,
    input  logic [OUT_WIDTH-1:0]   volume,
    input  logic                   loop,
    output logic [OUT_WIDTH-1:0]   level
);

    logic [DECAY_WIDTH-1:0] wrap_count_p0;

    // Decrement saturating at zero, or restart from volume when looping.
    function automatic logic [OUT_WIDTH-1:0] step_level(
        input logic [OUT_WIDTH-1:0] cur,
        input logic [OUT_WIDTH-1:0] vol,
        input logic                 lp
    );
        if (cur != '0) begin
            return cur - OUT_WIDTH'(1);
        end else if (lp) begin
            return vol;
        end
        return '0;
    endfunction

    // ---- stage p0: envelope state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= '0;
            wrap_count_p0 <= '0;
        end else if (load) begin
            level         <= volume;
            wrap_count_p0 <= '0;
        end else if (wrap && (period != '0)) begin
            if (wrap_count_p0 == period - DECAY_WIDTH'(1)) begin
                wrap_count_p0 <= '0;
                level         <= step_level(level, volume, loop);
            end else begin
                wrap_count_p0 <= wrap_count_p0 + DECAY_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_channel.sv
// Pulse-wave voice: phase accumulator, selectable duty, decaying/looping
// envelope and fully registered outputs.
// Ports:
//   i_clk, i_reset        - clock and synchronous active-high reset
//   i_note_valid          - one-cycle trigger sampling all i_note_* inputs
//   i_note_phase_delta    - phase increment per clock (0 = silence)
//   i_note_duty           - 0:12.5% 1:25% 2:50% 3:75%
//   i_note_volume         - initial envelope level
//   i_note_decay_period   - wraps per envelope step (0 = constant volume)
//   i_note_loop           - reload volume when the envelope reaches 0
//   o_output              - amplitude sample
//   o_frame_pulse         - one-cycle strobe on phase wrap
//   o_active              - envelope and delta both nonzero
module pulse_channel
    import pulse_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_WIDTH   = 9,
    parameter int DECAY_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_note_valid,
    input  logic [PHASE_WIDTH-1:0] i_note_phase_delta,
    input  logic [1:0]             i_note_duty,
    input  logic [OUT_WIDTH-1:0]   i_note_volume,
    input  logic [DECAY_WIDTH-1:0] i_note_decay_period,
    input  logic                   i_note_loop,
    output logic [OUT_WIDTH-1:0]   o_output,
    output logic                   o_frame_pulse,
    output logic                   o_active
);

    logic [PHASE_WIDTH-1:0] delta_p0;
    logic [PHASE_WIDTH-1:0] phase_p0;
    duty_e                  duty_p0;
    logic [OUT_WIDTH-1:0]   volume_p0;
    logic [DECAY_WIDTH-1:0] period_p0;
    logic                   loop_p0;
    logic [OUT_WIDTH-1:0]   level_p0;

    logic [PHASE_WIDTH:0]   phase_sum;
    logic                   wrap;
    logic [2:0]             phase_top;
    logic                   high;
    logic [OUT_WIDTH-1:0]   env_volume;

    // The carry out of the accumulator add is the wrap event.
    assign phase_sum = {1'b0, phase_p0} + {1'b0, delta_p0};
    assign wrap      = phase_sum[PHASE_WIDTH];
    assign phase_top = phase_p0[PHASE_WIDTH-1 -: 3];
    assign high      = (phase_top < duty_threshold(duty_p0));

    // On a trigger the envelope loads straight from the note input; otherwise
    // the stored volume is what a loop reloads.
    assign env_volume = i_note_valid ? i_note_volume : volume_p0;

    // ---- stage p0: note configuration and phase ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            delta_p0  <= '0;
            phase_p0  <= '0;
            duty_p0   <= DUTY_12;
            volume_p0 <= '0;
            period_p0 <= '0;
            loop_p0   <= 1'b0;
        end else if (i_note_valid) begin
            delta_p0  <= i_note_phase_delta;
            phase_p0  <= '0;
            duty_p0   <= duty_e'(i_note_duty);
            volume_p0 <= i_note_volume;
            period_p0 <= i_note_decay_period;
            loop_p0   <= i_note_loop;
        end else begin
            phase_p0  <= phase_sum[PHASE_WIDTH-1:0];
        end
    end

    // Trigger has priority over a coincident wrap inside the envelope.
    pulse_envelope #(
        .OUT_WIDTH  (OUT_WIDTH),
        .DECAY_WIDTH(DECAY_WIDTH)
    ) u_envelope (
        .clk   (i_clk),
        .rst   (i_reset),
        .load  (i_note_valid),
        .wrap  (wrap),
        .period(period_p0),
        .volume(env_volume),
        .loop  (loop_p0),
        .level (level_p0)
    );

    // ---- stage p1: registered outputs from current p0 state ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_output      <= '0;
            o_frame_pulse <= 1'b0;
            o_active      <= 1'b0;
        end else begin
            o_output      <= (high && (delta_p0 != '0)) ? level_p0 : '0;
            o_frame_pulse <= wrap && !i_note_valid;
            o_active      <= (level_p0 != '0) && (delta_p0 != '0);
        end
    end

endmodule

// File: tb/tb_pulse_channel.sv
// Bench for pulse_channel: directed scenarios plus randomized notes, each
// cycle compared against an arithmetic model of the voice (phase = n*delta,
// wraps = floor(n*delta / 2^PW), envelope level derived from the wrap total).
module tb_pulse_channel;

    localparam int PW = 32;
    localparam int OW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          note_valid = 1'b0;
    logic [PW-1:0] note_delta = '0;
    logic [1:0]    note_duty = '0;
    logic [OW-1:0] note_volume = '0;
    logic [DW-1:0] note_period = '0;
    logic          note_loop = 1'b0;
    logic [OW-1:0] out_sample;
    logic          frame_pulse;
    logic          active;

    int tests  = 0;
    int errors = 0;

    // Reference model state
    longint unsigned m_n     = 0;
    longint unsigned m_delta = 0;
    int              m_duty  = 0;
    longint unsigned m_vol   = 0;
    longint unsigned m_per   = 0;
    bit              m_loop  = 1'b0;

    always #5 clk = ~clk;

    pulse_channel #(
        .PHASE_WIDTH(PW),
        .OUT_WIDTH  (OW),
        .DECAY_WIDTH(DW)
    ) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_note_valid       (note_valid),
        .i_note_phase_delta (note_delta),
        .i_note_duty        (note_duty),
        .i_note_volume      (note_volume),
        .i_note_decay_period(note_period),
        .i_note_loop        (note_loop),
        .o_output           (out_sample),
        .o_frame_pulse      (frame_pulse),
        .o_active           (active)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint unsigned level_of(input longint unsigned wraps);
        longint unsigned steps;
        if (m_per == 0) return m_vol;
        steps = wraps / m_per;
        if (m_loop) return m_vol - (steps % (m_vol + 1));
        return (steps >= m_vol) ? 0 : m_vol - steps;
    endfunction

    function automatic int eighths_high(input int duty);
        case (duty)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 6;
        endcase
    endfunction

    // One clock: predict registered outputs from model state + inputs, clock,
    // compare, then advance the model.
    task automatic step(input bit v, input bit r);
        longint unsigned full, acc, ph, w0, w1, lvl;
        longint unsigned e_out;
        bit high, e_frame, e_act;
        note_valid = v;
        rst        = r;
        full = 64'd1 << PW;
        acc  = m_n * m_delta;
        ph   = acc % full;
        w0   = acc / full;
        w1   = (acc + m_delta) / full;
        lvl  = level_of(w0);
        high = (ph * 8) < (longint'(eighths_high(m_duty)) * full);
        e_out   = (high && m_delta != 0) ? lvl : 0;
        e_frame = (w1 > w0) && !v;
        e_act   = (lvl != 0) && (m_delta != 0);
        if (r) begin
            e_out = 0; e_frame = 1'b0; e_act = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("output", longint'(out_sample), longint'(e_out));
        check_eq("frame", longint'(frame_pulse), longint'(e_frame));
        check_eq("active", longint'(active), longint'(e_act));
        if (r) begin
            m_n = 0; m_delta = 0; m_duty = 0; m_vol = 0; m_per = 0; m_loop = 1'b0;
        end else if (v) begin
            m_n = 0; m_delta = note_delta; m_duty = note_duty;
            m_vol = note_volume; m_per = note_period; m_loop = note_loop;
        end else begin
            m_n++;
        end
    endtask

    task automatic trig(input logic [PW-1:0] d, input int duty, input int vol,
                        input int per, input bit lp);
        note_delta  = d;
        note_duty   = duty[1:0];
        note_volume = vol[OW-1:0];
        note_period = per[DW-1:0];
        note_loop   = lp;
        step(1'b1, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int hi_cnt, fr_cnt;
        // Reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("rst_output", longint'(out_sample), 0);
        check_eq("rst_active", longint'(active), 0);

        // 50% duty, 16-clock period, constant volume 255
        trig(32'h1000_0000, 2, 255, 0, 1'b0);
        hi_cnt = 0; fr_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0);
            if (i == 0) check_eq("first_high", longint'(out_sample), 255);
            if (out_sample != 0) hi_cnt++;
            if (frame_pulse) fr_cnt++;
        end
        check_eq("hi50_32cyc", hi_cnt, 16);
        check_eq("frames_32cyc", fr_cnt, 2);

        // Duty sweep
        for (int d = 0; d < 4; d++) begin
            trig(32'h1000_0000, d, 255, 0, 1'b0);
            hi_cnt = 0;
            for (int i = 0; i < 16; i++) begin
                step(1'b0, 1'b0);
                if (out_sample != 0) hi_cnt++;
            end
            check_eq("duty_high_count", hi_cnt, (d == 0) ? 2 : (d == 1) ? 4 : (d == 2) ? 8 : 12);
        end

        // Decay without and with loop
        trig(32'h1000_0000, 2, 3, 2, 1'b0);
        run(200);
        check_eq("decay_active_end", longint'(active), 0);
        check_eq("decay_output_end", longint'(out_sample), 0);
        trig(32'h1000_0000, 2, 3, 2, 1'b1);
        run(200);

        // Re-trigger on the wrap/step cycle
        trig(32'h1000_0000, 2, 5, 1, 1'b0);
        run(15);
        trig(32'h1000_0000, 2, 77, 1, 1'b0);
        check_eq("retrig_no_frame", longint'(frame_pulse), 0);
        step(1'b0, 1'b0);
        check_eq("retrig_new_vol", longint'(out_sample), 77);
        run(20);

        // Reset mid-note
        trig(32'h1000_0000, 3, 200, 1, 1'b1);
        run(20);
        step(1'b0, 1'b1);
        check_eq("midrst_output", longint'(out_sample), 0);
        check_eq("midrst_frame", longint'(frame_pulse), 0);
        check_eq("midrst_active", longint'(active), 0);
        run(40);

        // Zero delta
        trig(32'h0000_0000, 2, 100, 1, 1'b0);
        fr_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (frame_pulse) fr_cnt++;
        end
        check_eq("zero_delta_frames", fr_cnt, 0);
        check_eq("zero_delta_active", longint'(active), 0);

        // Randomized notes, resets and back-to-back triggers
        for (int c = 0; c < 4000; c++) begin
            bit v, r;
            v = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 299) == 0);
            if (v) begin
                case ($urandom_range(0, 4))
                    0: note_delta = 32'h1000_0000;
                    1: note_delta = 32'h0800_0000;
                    2: note_delta = $urandom;
                    3: note_delta = '0;
                    default: note_delta = $urandom_range(32'h0100_0000, 32'h2000_0000);
                endcase
                note_duty   = 2'($urandom_range(0, 3));
                note_volume = ($urandom_range(0, 1) == 1) ? OW'($urandom_range(0, 7))
                                                           : OW'($urandom_range(0, 511));
                note_period = DW'($urandom_range(0, 3));
                note_loop   = 1'($urandom_range(0, 1));
            end
            step(v, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pulse_channel.md
# pulse_channel

Parametrised pulse-wave voice generator with selectable duty cycle, per-note trigger handshake, and a decaying/looping volume envelope. It accepts note events from a sequencer, runs its own phase accumulator, and emits an unsigned amplitude sample to the PWM mixer stage. It also emits a one-cycle period-wrap strobe for visualisation and sync. It succeeds the fixed 75%-duty, externally-enveloped pulse channel and generalises phase width, output width and duty.

## Interface
- PHASE_WIDTH, 32, phase accumulator width (≥4)
- OUT_WIDTH, 9, amplitude/volume width
- DECAY_WIDTH, 8, width of decay-period field and wrap counter
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_note_valid  in  1  one-cycle trigger; samples all i_note_* / config inputs
- i_note_phase_delta  in  PHASE_WIDTH  phase increment per clock; 0 = silence
- i_note_duty  in  2  0:12.5%, 1:25%, 2:50%, 3:75%
- i_note_volume  in  OUT_WIDTH  initial envelope level
- i_note_decay_period  in  DECAY_WIDTH  wraps per envelope step; 0 = constant volume
- i_note_loop  in  1  reload volume when envelope reaches 0
- o_output  out  OUT_WIDTH  registered amplitude sample
- o_frame_pulse  out  1  registered one-cycle strobe on phase wrap
- o_active  out  1  envelope nonzero and delta nonzero

## Operation
- Registers: delta, duty, volume, decay_period, loop, phase, envelope, wrap_count; all reset to 0. Outputs reset to 0.
- Trigger (i_note_valid=1): next cycle delta/duty/volume/period/loop hold sampled values, phase=0, envelope=i_note_volume, wrap_count=0. Re-trigger while sounding restarts identically (no glitch state retained).
- Accumulator: each non-trigger cycle phase <= phase + delta, modulo 2^PHASE_WIDTH. Wrap = carry out of that add.
- Duty: let t = phase[PHASE_WIDTH-1 -: 3]. High when t < threshold; thresholds 1, 2, 4, 6 for duty 0..3.
- Envelope step on wrap when decay_period≠0: if wrap_count == decay_period-1 then wrap_count=0 and step, else wrap_count++. Step: envelope>0 → envelope-1; envelope==0 and loop → envelope=volume; envelope==0 and !loop → hold 0.
- decay_period==0: envelope holds, wrap_count holds at 0.
- Trigger and wrap same cycle: trigger wins; no step, no frame pulse.
- Sample: o_output <= (high && delta≠0) ? envelope : 0. Uses the current (pre-update) phase and envelope.
- o_frame_pulse <= wrap && !i_note_valid.
- o_active <= envelope≠0 && delta≠0.

## Timing
- Trigger at cycle T: state loaded at T+1. First output reflecting the new note, phase=0 (high for duty≥0), is at T+2.
- Output latency from phase/envelope state: 1 cycle (fully registered outputs).
- No backpressure; i_note_valid is accepted every cycle, including back-to-back.
- Reset asserted mid-note: all state and outputs 0 on the next edge. Silent until the next trigger.
- Wrap with delta ≥ 2^(PHASE_WIDTH-1): one wrap per add at most; behaviour is defined by the modulo arithmetic only.
- Envelope arithmetic unsigned. Never underflows below 0 and never exceeds the loaded volume.

## Structure
- Package pulse_pkg: duty enum (DUTY_12, DUTY_25, DUTY_50, DUTY_75) and 3-bit threshold constant array {1,2,4,6}.
- Sub-module pulse_envelope: envelope, wrap_count, loop/reload and step logic. Inputs: load, wrap, period, volume, loop. Output: level.
- Top module: phase accumulator, duty compare, output registers.

## Test plan
- Reset then trigger delta=2^28, duty=2 (50%), volume=255, period=0 with PHASE_WIDTH=32 → period 16 clocks. o_output=255 for 8 cycles, then 0 for 8. o_frame_pulse every 16 cycles. First high at T+2.
- Duty sweep with delta=2^28 → high counts per 16-cycle period of 2, 4, 8, 12 for duty 0..3.
- Decay: volume=3, period=2, loop=0 → level steps 3→2→1→0 every 2 wraps. Then o_output=0 and o_active=0 permanently. Repeat with loop=1 → level returns to 3 after 0.
- Re-trigger at the same cycle as a scheduled wrap/step → no frame pulse that cycle. Envelope equals the new volume and phase is 0 on the next cycle.
- Assert reset mid-note for one cycle → all outputs 0 the following cycle and remain 0 without a new trigger.
- delta=0 with volume=100 → o_output=0, o_frame_pulse never asserts, o_active=0.
